// File: rtl/tdc_pkg.sv
// Shared definitions for the TDC measurement sequencer: state encoding and
// default datapath widths.
package tdc_pkg;

  localparam int COARSE_W_DEF = 16;
  localparam int FINE_W_DEF   = 8;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_WAIT_START = 3'd1,
    ST_WAIT_STOP  = 3'd2,
    ST_DONE       = 3'd3,
    ST_REARM      = 3'd4
  } tdc_state_e;

  // The sequencer counts as busy in every state except IDLE.
  function automatic logic tdc_is_busy(input tdc_state_e st);
    return (st != ST_IDLE);
  endfunction

endpackage

// File: rtl/tdc_edge_det.sv
// Registered rising-edge detector for one filter valid line. The history
// register is updated every cycle, so a level held across several cycles
// produces exactly one detect pulse, in the first cycle it is seen high.
module tdc_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic valid_i,
  output logic rise_o
);

  logic valid_q;

  // Keep one cycle of valid history.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) valid_q <= 1'b0;
    else     valid_q <= valid_i;
  end

  assign rise_o = valid_i & ~valid_q;

endmodule

// File: rtl/tdc_meas_sequencer.sv
// Start/stop TDC measurement sequencer. It arms the start and stop hit gates,
// latches each channel's fine code when that channel's filter valid rises,
// counts coarse cycles between the two edges, and aborts with a timeout if
// no stop edge arrives. It then presents the result over valid/ready and
// waits a holdoff period before it accepts another arm.
module tdc_meas_sequencer #(
  parameter int COARSE_W = tdc_pkg::COARSE_W_DEF,
  parameter int FINE_W   = tdc_pkg::FINE_W_DEF,
  parameter int TIMEOUT  = 1000,
  parameter int HOLDOFF  = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                arm,
  input  logic                start_valid,
  input  logic                stop_valid,
  input  logic [FINE_W-1:0]   start_fine,
  input  logic [FINE_W-1:0]   stop_fine,
  output logic                hit_en_start,
  output logic                hit_en_stop,
  output logic                busy,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [COARSE_W-1:0] res_coarse,
  output logic [FINE_W-1:0]   res_start_fine,
  output logic [FINE_W-1:0]   res_stop_fine,
  output logic                res_timeout
);

  import tdc_pkg::*;

  // TIMEOUT < 2**COARSE_W, so the coarse counter stops before it can wrap.
  localparam logic [COARSE_W-1:0] TIMEOUT_C    = COARSE_W'(TIMEOUT);
  localparam int                  HO_W         = $clog2(HOLDOFF + 1);
  localparam logic [HO_W-1:0]     HOLDOFF_LAST = HO_W'(HOLDOFF - 1);

  tdc_state_e          state_q, state_d;
  logic [COARSE_W-1:0] coarse_q, coarse_d;
  logic [COARSE_W-1:0] coarse_inc;
  logic [HO_W-1:0]     holdoff_q, holdoff_d;
  logic                hit_en_start_q, hit_en_start_d;
  logic                hit_en_stop_q, hit_en_stop_d;
  logic                res_valid_q, res_valid_d;
  logic [COARSE_W-1:0] res_coarse_q, res_coarse_d;
  logic [FINE_W-1:0]   res_start_fine_q, res_start_fine_d;
  logic [FINE_W-1:0]   res_stop_fine_q, res_stop_fine_d;
  logic                res_timeout_q, res_timeout_d;
  logic                s_rise, p_rise;

  tdc_edge_det u_start_edge (
    .clk     (clk),
    .rst     (rst),
    .valid_i (start_valid),
    .rise_o  (s_rise)
  );

  tdc_edge_det u_stop_edge (
    .clk     (clk),
    .rst     (rst),
    .valid_i (stop_valid),
    .rise_o  (p_rise)
  );

  assign coarse_inc = coarse_q + COARSE_W'(1);

  // Next-state, gate and result logic; every register holds its value unless a case below changes it.
  always_comb begin
    state_d          = state_q;
    coarse_d         = coarse_q;
    holdoff_d        = holdoff_q;
    hit_en_start_d   = hit_en_start_q;
    hit_en_stop_d    = hit_en_stop_q;
    res_valid_d      = res_valid_q;
    res_coarse_d     = res_coarse_q;
    res_start_fine_d = res_start_fine_q;
    res_stop_fine_d  = res_stop_fine_q;
    res_timeout_d    = res_timeout_q;

    unique case (state_q)
      ST_IDLE: begin
        if (arm) begin
          state_d        = ST_WAIT_START;
          hit_en_start_d = 1'b1;
          hit_en_stop_d  = 1'b1;
        end
      end

      // A stop edge on its own is ignored here; only a start edge advances.
      ST_WAIT_START: begin
        if (s_rise) begin
          res_start_fine_d = start_fine;
          coarse_d         = '0;
          hit_en_start_d   = 1'b0;
          if (p_rise) begin
            res_stop_fine_d = stop_fine;
            res_coarse_d    = '0;
            res_timeout_d   = 1'b0;
            hit_en_stop_d   = 1'b0;
            res_valid_d     = 1'b1;
            state_d         = ST_DONE;
          end else begin
            state_d = ST_WAIT_STOP;
          end
        end
      end

      // A stop edge takes priority over a timeout that expires in the same cycle.
      ST_WAIT_STOP: begin
        coarse_d = coarse_inc;
        if (p_rise) begin
          res_stop_fine_d = stop_fine;
          res_coarse_d    = coarse_inc;
          res_timeout_d   = 1'b0;
          hit_en_stop_d   = 1'b0;
          res_valid_d     = 1'b1;
          state_d         = ST_DONE;
        end else if (coarse_inc == TIMEOUT_C) begin
          res_stop_fine_d = '0;
          res_coarse_d    = TIMEOUT_C;
          res_timeout_d   = 1'b1;
          hit_en_stop_d   = 1'b0;
          res_valid_d     = 1'b1;
          state_d         = ST_DONE;
        end
      end

      // Hold the result for as long as the readout needs; no timeout applies here.
      ST_DONE: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          holdoff_d   = '0;
          state_d     = ST_REARM;
        end
      end

      // Give the filters time to finish before the next measurement is armed.
      ST_REARM: begin
        hit_en_start_d = 1'b0;
        hit_en_stop_d  = 1'b0;
        if (holdoff_q == HOLDOFF_LAST) begin
          state_d = ST_IDLE;
        end else begin
          holdoff_d = holdoff_q + HO_W'(1);
        end
      end

      default: begin
        state_d        = ST_IDLE;
        hit_en_start_d = 1'b0;
        hit_en_stop_d  = 1'b0;
        res_valid_d    = 1'b0;
      end
    endcase
  end

  // State, counter and result registers; reset discards any pending result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= ST_IDLE;
      coarse_q         <= '0;
      holdoff_q        <= '0;
      hit_en_start_q   <= 1'b0;
      hit_en_stop_q    <= 1'b0;
      res_valid_q      <= 1'b0;
      res_coarse_q     <= '0;
      res_start_fine_q <= '0;
      res_stop_fine_q  <= '0;
      res_timeout_q    <= 1'b0;
    end else begin
      state_q          <= state_d;
      coarse_q         <= coarse_d;
      holdoff_q        <= holdoff_d;
      hit_en_start_q   <= hit_en_start_d;
      hit_en_stop_q    <= hit_en_stop_d;
      res_valid_q      <= res_valid_d;
      res_coarse_q     <= res_coarse_d;
      res_start_fine_q <= res_start_fine_d;
      res_stop_fine_q  <= res_stop_fine_d;
      res_timeout_q    <= res_timeout_d;
    end
  end

  assign busy           = tdc_is_busy(state_q);
  assign hit_en_start   = hit_en_start_q;
  assign hit_en_stop    = hit_en_stop_q;
  assign res_valid      = res_valid_q;
  assign res_coarse     = res_coarse_q;
  assign res_start_fine = res_start_fine_q;
  assign res_stop_fine  = res_stop_fine_q;
  assign res_timeout    = res_timeout_q;

endmodule

// File: tb/tb_tdc_meas_sequencer.sv
// Directed bench for tdc_meas_sequencer: normal, coincident, timeout,
// stop-first with arm spam, backpressure, and reset in the middle of a measurement.
module tb_tdc_meas_sequencer;

  localparam int COARSE_W = 16;
  localparam int FINE_W   = 8;
  localparam int TIMEOUT  = 20;
  localparam int HOLDOFF  = 4;

  logic                clk = 1'b0;
  logic                rst;
  logic                arm;
  logic                start_valid;
  logic                stop_valid;
  logic [FINE_W-1:0]   start_fine;
  logic [FINE_W-1:0]   stop_fine;
  logic                hit_en_start;
  logic                hit_en_stop;
  logic                busy;
  logic                res_valid;
  logic                res_ready;
  logic [COARSE_W-1:0] res_coarse;
  logic [FINE_W-1:0]   res_start_fine;
  logic [FINE_W-1:0]   res_stop_fine;
  logic                res_timeout;

  int n_checks = 0;
  int n_errs   = 0;

  tdc_meas_sequencer #(
    .COARSE_W (COARSE_W),
    .FINE_W   (FINE_W),
    .TIMEOUT  (TIMEOUT),
    .HOLDOFF  (HOLDOFF)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .arm            (arm),
    .start_valid    (start_valid),
    .stop_valid     (stop_valid),
    .start_fine     (start_fine),
    .stop_fine      (stop_fine),
    .hit_en_start   (hit_en_start),
    .hit_en_stop    (hit_en_stop),
    .busy           (busy),
    .res_valid      (res_valid),
    .res_ready      (res_ready),
    .res_coarse     (res_coarse),
    .res_start_fine (res_start_fine),
    .res_stop_fine  (res_stop_fine),
    .res_timeout    (res_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept the pending result, then expect HOLDOFF cycles of REARM before IDLE.
  task automatic accept_and_rearm(input string tag);
    res_ready = 1'b1;
    tick();
    chk({tag, "_vld_drop"}, res_valid, 1'b0);
    chk({tag, "_rearm_busy"}, busy, 1'b1);
    res_ready = 1'b0;
    repeat (HOLDOFF - 1) tick();
    chk({tag, "_holdoff_busy"}, busy, 1'b1);
    tick();
    chk({tag, "_idle"}, busy, 1'b0);
  endtask

  int unstable;

  initial begin
    rst = 1'b1; arm = 1'b0; start_valid = 1'b0; stop_valid = 1'b0;
    start_fine = '0; stop_fine = '0; res_ready = 1'b0;
    repeat (2) tick();

    // Reset state
    chk("rst_busy", busy, 1'b0);
    chk("rst_hit_start", hit_en_start, 1'b0);
    chk("rst_hit_stop", hit_en_stop, 1'b0);
    chk("rst_valid", res_valid, 1'b0);
    chk("rst_coarse", res_coarse, 16'd0);
    rst = 1'b0;
    tick();

    // 1 Normal: stop edge 15 cycles after start edge
    res_ready = 1'b1;  // early ready must be ignored
    arm = 1'b1;
    tick();
    arm = 1'b0;
    chk("n_hit_start", hit_en_start, 1'b1);
    chk("n_hit_stop", hit_en_stop, 1'b1);
    chk("n_busy", busy, 1'b1);
    start_valid = 1'b1; start_fine = 8'hA5;
    tick();
    chk("n_hit_start_off", hit_en_start, 1'b0);
    chk("n_hit_stop_on", hit_en_stop, 1'b1);
    tick();
    start_valid = 1'b0;
    repeat (13) tick();
    chk("n_no_vld_yet", res_valid, 1'b0);
    stop_valid = 1'b1; stop_fine = 8'h3C;
    tick();
    res_ready = 1'b0;
    chk("n_vld", res_valid, 1'b1);
    chk("n_coarse", res_coarse, 16'd15);
    chk("n_sfine", res_start_fine, 8'hA5);
    chk("n_pfine", res_stop_fine, 8'h3C);
    chk("n_tmo", res_timeout, 1'b0);
    chk("n_hit_stop_off", hit_en_stop, 1'b0);
    stop_valid = 1'b0;
    tick();
    chk("n_hold_vld", res_valid, 1'b1);
    accept_and_rearm("n");

    // 2 Coincident start and stop edges
    arm = 1'b1;
    tick();
    arm = 1'b0;
    start_valid = 1'b1; stop_valid = 1'b1;
    start_fine = 8'h11; stop_fine = 8'h22;
    tick();
    chk("c_vld", res_valid, 1'b1);
    chk("c_coarse", res_coarse, 16'd0);
    chk("c_sfine", res_start_fine, 8'h11);
    chk("c_pfine", res_stop_fine, 8'h22);
    chk("c_hits", {hit_en_start, hit_en_stop}, 2'b00);
    start_valid = 1'b0; stop_valid = 1'b0;
    accept_and_rearm("c");

    // 3 Timeout: start only
    arm = 1'b1;
    tick();
    arm = 1'b0;
    start_valid = 1'b1; start_fine = 8'h5A;
    tick();
    start_valid = 1'b0;
    repeat (TIMEOUT - 1) tick();
    chk("t_no_vld_yet", res_valid, 1'b0);
    chk("t_hit_stop_on", hit_en_stop, 1'b1);
    tick();
    chk("t_vld", res_valid, 1'b1);
    chk("t_tmo", res_timeout, 1'b1);
    chk("t_coarse", res_coarse, 16'd20);
    chk("t_pfine", res_stop_fine, 8'h00);
    chk("t_sfine", res_start_fine, 8'h5A);
    chk("t_hit_stop_off", hit_en_stop, 1'b0);
    accept_and_rearm("t");

    // 4 Stop-first is ignored; arm pulses outside IDLE are dropped
    arm = 1'b1;
    tick();
    arm = 1'b0;
    stop_valid = 1'b1; stop_fine = 8'h99;
    tick();
    chk("s_stop_ignored", res_valid, 1'b0);
    chk("s_still_armed", hit_en_stop, 1'b1);
    stop_valid = 1'b0;
    tick();
    start_valid = 1'b1; start_fine = 8'h42;
    tick();
    start_valid = 1'b0;
    arm = 1'b1;
    repeat (4) tick();
    stop_valid = 1'b1; stop_fine = 8'h24;
    tick();
    stop_valid = 1'b0;
    chk("s_vld", res_valid, 1'b1);
    chk("s_coarse", res_coarse, 16'd5);
    chk("s_tmo", res_timeout, 1'b0);
    chk("s_pfine", res_stop_fine, 8'h24);
    tick();
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk("s_vld_drop", res_valid, 1'b0);
    repeat (HOLDOFF - 1) tick();
    chk("s_rearm_vld", res_valid, 1'b0);
    arm = 1'b0;
    tick();
    chk("s_idle", busy, 1'b0);
    repeat (3) tick();
    chk("s_no_rearm", busy, 1'b0);
    chk("s_no_gates", {hit_en_start, hit_en_stop}, 2'b00);
    chk("s_no_extra", res_valid, 1'b0);

    // 5 Backpressure: ready low for 50 cycles in DONE
    arm = 1'b1;
    tick();
    arm = 1'b0;
    start_valid = 1'b1; start_fine = 8'hC3;
    tick();
    start_valid = 1'b0;
    repeat (2) tick();
    stop_valid = 1'b1; stop_fine = 8'h7E;
    tick();
    stop_valid = 1'b0;
    unstable = 0;
    for (int i = 0; i < 50; i++) begin
      if (res_valid !== 1'b1 || res_coarse !== 16'd3 || res_start_fine !== 8'hC3 ||
          res_stop_fine !== 8'h7E || res_timeout !== 1'b0)
        unstable++;
      tick();
    end
    chk("b_unstable_cycles", unstable, 0);
    chk("b_vld", res_valid, 1'b1);
    chk("b_tmo", res_timeout, 1'b0);
    accept_and_rearm("b");

    // 6 Async reset in the middle of WAIT_STOP
    arm = 1'b1;
    tick();
    arm = 1'b0;
    start_valid = 1'b1; start_fine = 8'hE1;
    tick();
    start_valid = 1'b0;
    repeat (3) tick();
    #2;
    rst = 1'b1;
    #1;
    chk("r_busy", busy, 1'b0);
    chk("r_hits", {hit_en_start, hit_en_stop}, 2'b00);
    chk("r_vld", res_valid, 1'b0);
    chk("r_coarse", res_coarse, 16'd0);
    chk("r_sfine", res_start_fine, 8'h00);
    tick();
    rst = 1'b0;
    tick();
    arm = 1'b1;
    tick();
    arm = 1'b0;
    start_valid = 1'b1; start_fine = 8'h0F;
    tick();
    start_valid = 1'b0;
    repeat (6) tick();
    stop_valid = 1'b1; stop_fine = 8'hF0;
    tick();
    stop_valid = 1'b0;
    chk("r2_vld", res_valid, 1'b1);
    chk("r2_coarse", res_coarse, 16'd7);
    chk("r2_sfine", res_start_fine, 8'h0F);
    chk("r2_pfine", res_stop_fine, 8'hF0);
    chk("r2_tmo", res_timeout, 1'b0);
    accept_and_rearm("r2");

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
